subpixel_interpolation: RTL and testbench

SUBPIXEL_INTERPOLATION -- requirements
Module: subpixel_interpolation

---
 rtl/subpixel_interpolation.sv | 150 +++++++++++++++
 tb/tb_subpixel_interpolation.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/subpixel_interpolation.sv
// Horizontal 8-tap sub-pixel interpolator for a row-streamed luma block.
//
// A 15-pixel row is fetched every cycle (in_row is addressed by next_row),
// latched into currentPixels, and filtered into three 8-pixel rows at the
// quarter (a), half (b) and three-quarter (c) positions.  The filtered rows
// are shifted into 15-row history buffers; load_out pulses for one cycle each
// time another 15 rows have been shifted in.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   in_row         15 pixels of the addressed row, p[i] = in_row[8i+7:8i]
//   next_row       registered index of the row to present on in_row
//   currentPixels  registered row being filtered
//   fir_out_a/b/c  8 filtered pixels (combinational from currentPixels)
//   temp_A/B/C     15-row history of fir_out_a/b/c, oldest row in [63:0]
//   cnt            rows accumulated in the current block, 0..14
//   load_out       one-cycle pulse when a 15-row block completes
//   so             completed-block counter (wraps at 8 bits)
module subpixel_interpolation (
   input  logic           clk,
   input  logic           rst,
   input  logic [119:0]   in_row,
   output logic [63:0]    next_row,
   output logic [119:0]   currentPixels,
   output logic [63:0]    fir_out_a,
   output logic [63:0]    fir_out_b,
   output logic [63:0]    fir_out_c,
   output logic [959:0]   temp_A,
   output logic [959:0]   temp_B,
   output logic [959:0]   temp_C,
   output logic [7:0]     cnt,
   output logic           load_out,
   output logic [7:0]     so
);

   // Tap k occupies byte k (two's complement).
   localparam logic [63:0] COEF_A = {8'h00, 8'h01, 8'hFB, 8'h11, 8'h3A, 8'hF6, 8'h04, 8'hFF};
   localparam logic [63:0] COEF_B = {8'hFF, 8'h04, 8'hF5, 8'h28, 8'h28, 8'hF5, 8'h04, 8'hFF};
   localparam logic [63:0] COEF_C = {8'hFF, 8'h04, 8'hF6, 8'h3A, 8'h11, 8'hFB, 8'h01, 8'h00};

   // One output pixel: signed 8-tap sum over an 8-pixel window, rounded by
   // +32 then >>>6, clipped to 0..255.  20 bits cannot overflow here.
   function automatic logic [7:0] fir_px(input logic [63:0] win, input logic [63:0] coef);
      logic signed [19:0] acc;
      logic signed [19:0] pix;
      logic signed [19:0] co;
      logic signed [19:0] rnd;
      acc = '0;
      for (int unsigned k = 0; k < 8; k++) begin
         pix = {12'd0, win[8*k +: 8]};
         co  = {{12{coef[8*k+7]}}, coef[8*k +: 8]};
         acc = acc + pix * co;
      end
      rnd = (acc + 20'sd32) >>> 6;
      if (rnd < 20'sd0)
         fir_px = 8'h00;
      else if (rnd > 20'sd255)
         fir_px = 8'hFF;
      else
         fir_px = rnd[7:0];
   endfunction

   logic [63:0]  next_row_q, next_row_d;
   logic [119:0] cur_q, cur_d;
   logic         valid_q, valid_d;
   logic [959:0] temp_a_q, temp_a_d;
   logic [959:0] temp_b_q, temp_b_d;
   logic [959:0] temp_c_q, temp_c_d;
   logic [7:0]   cnt_q, cnt_d;
   logic         load_q, load_d;
   logic [7:0]   so_q, so_d;

   logic [63:0]  fir_a, fir_b, fir_c;

   // Output j uses pixels p[j..j+7].
   always_comb begin
      fir_a = '0;
      fir_b = '0;
      fir_c = '0;
      for (int unsigned j = 0; j < 8; j++) begin
         fir_a[8*j +: 8] = fir_px(cur_q[8*j +: 64], COEF_A);
         fir_b[8*j +: 8] = fir_px(cur_q[8*j +: 64], COEF_B);
         fir_c[8*j +: 8] = fir_px(cur_q[8*j +: 64], COEF_C);
      end
   end

   always_comb begin
      next_row_d = next_row_q + 64'd1;
      cur_d      = in_row;
      valid_d    = 1'b1;
      temp_a_d   = temp_a_q;
      temp_b_d   = temp_b_q;
      temp_c_d   = temp_c_q;
      cnt_d      = cnt_q;
      load_d     = 1'b0;
      so_d       = so_q;
      // valid_q marks that cur_q holds a fetched row; the first edge after
      // reset only loads it, so shifting lags fetching by one cycle.
      if (valid_q) begin
         temp_a_d = {fir_a, temp_a_q[959:64]};
         temp_b_d = {fir_b, temp_b_q[959:64]};
         temp_c_d = {fir_c, temp_c_q[959:64]};
         if (cnt_q == 8'd14) begin
            cnt_d  = '0;
            load_d = 1'b1;
            so_d   = so_q + 8'd1;
         end else begin
            cnt_d  = cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         next_row_q <= '0;
         cur_q      <= '0;
         valid_q    <= 1'b0;
         temp_a_q   <= '0;
         temp_b_q   <= '0;
         temp_c_q   <= '0;
         cnt_q      <= '0;
         load_q     <= 1'b0;
         so_q       <= '0;
      end else begin
         next_row_q <= next_row_d;
         cur_q      <= cur_d;
         valid_q    <= valid_d;
         temp_a_q   <= temp_a_d;
         temp_b_q   <= temp_b_d;
         temp_c_q   <= temp_c_d;
         cnt_q      <= cnt_d;
         load_q     <= load_d;
         so_q       <= so_d;
      end
   end

   assign next_row      = next_row_q;
   assign currentPixels = cur_q;
   assign fir_out_a     = fir_a;
   assign fir_out_b     = fir_b;
   assign fir_out_c     = fir_c;
   assign temp_A        = temp_a_q;
   assign temp_B        = temp_b_q;
   assign temp_C        = temp_c_q;
   assign cnt           = cnt_q;
   assign load_out      = load_q;
   assign so            = so_q;

endmodule

// File: tb/tb_subpixel_interpolation.sv
// Testbench for subpixel_interpolation: fixed filter vectors from a table,
// then random rows checked cycle by cycle against an arithmetic model.
module tb_subpixel_interpolation;

   logic           clk = 1'b0;
   logic           rst;
   logic [119:0]   in_row;
   logic [63:0]    next_row;
   logic [119:0]   currentPixels;
   logic [63:0]    fir_out_a, fir_out_b, fir_out_c;
   logic [959:0]   temp_A, temp_B, temp_C;
   logic [7:0]     cnt;
   logic           load_out;
   logic [7:0]     so;

   int tests = 0;
   int fails = 0;

   logic [119:0] rows [64];
   logic [119:0] fixed_row;
   logic         use_fixed;

   always #5 clk = ~clk;

   // Row memory seen by the DUT: a pure function of next_row.
   assign in_row = use_fixed ? fixed_row : rows[next_row[5:0]];

   subpixel_interpolation dut (
      .clk           (clk),
      .rst           (rst),
      .in_row        (in_row),
      .next_row      (next_row),
      .currentPixels (currentPixels),
      .fir_out_a     (fir_out_a),
      .fir_out_b     (fir_out_b),
      .fir_out_c     (fir_out_c),
      .temp_A        (temp_A),
      .temp_B        (temp_B),
      .temp_C        (temp_C),
      .cnt           (cnt),
      .load_out      (load_out),
      .so            (so)
   );

   typedef struct {
      logic [119:0] row;
      logic [63:0]  ea;
      logic [63:0]  eb;
      logic [63:0]  ec;
   } vec_t;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Floor division by 64 written out explicitly for negative sums.
   function automatic int floor64(input int x);
      if (x >= 0) return x / 64;
      return -((-x + 63) / 64);
   endfunction

   function automatic logic [63:0] ref_fir(input logic [119:0] row, input int sel);
      int coef [8];
      int sum;
      int v;
      logic [63:0] res;
      case (sel)
         0:       coef = '{-1, 4, -10, 58, 17, -5, 1, 0};
         1:       coef = '{-1, 4, -11, 40, 40, -11, 4, -1};
         default: coef = '{0, 1, -5, 17, 58, -10, 4, -1};
      endcase
      res = '0;
      for (int j = 0; j < 8; j++) begin
         sum = 0;
         for (int k = 0; k < 8; k++)
            sum += coef[k] * int'(row[8*(j+k) +: 8]);
         v = floor64(sum + 32);
         if (v < 0) v = 0;
         if (v > 255) v = 255;
         res[8*j +: 8] = 8'(v);
      end
      return res;
   endfunction

   function automatic logic [119:0] row_at(input int r);
      return rows[r % 64];
   endfunction

   // Expected state after n edges since reset release (n=0: in reset).
   task automatic check_state(input int n);
      logic [119:0] exp_cur;
      logic [63:0]  slot_exp;
      logic [959:0] tq;
      int s, m;
      if (n == 0) begin
         chk("next_row", 128'(next_row), 128'd0);
         chk("currentPixels", 128'(currentPixels), 128'd0);
         chk("fir_out_a", 128'(fir_out_a), 128'd0);
         chk("fir_out_b", 128'(fir_out_b), 128'd0);
         chk("fir_out_c", 128'(fir_out_c), 128'd0);
         chk("cnt", 128'(cnt), 128'd0);
         chk("load_out", 128'(load_out), 128'd0);
         chk("so", 128'(so), 128'd0);
         chk("temp_zero", 128'((temp_A | temp_B | temp_C) != '0), 128'd0);
         return;
      end
      s = n - 1;
      exp_cur = row_at(n - 1);
      chk("next_row", 128'(next_row), 128'(n));
      chk("currentPixels", 128'(currentPixels), 128'(exp_cur));
      chk("fir_out_a", 128'(fir_out_a), 128'(ref_fir(exp_cur, 0)));
      chk("fir_out_b", 128'(fir_out_b), 128'(ref_fir(exp_cur, 1)));
      chk("fir_out_c", 128'(fir_out_c), 128'(ref_fir(exp_cur, 2)));
      chk("cnt", 128'(cnt), 128'(s % 15));
      chk("load_out", 128'(load_out), 128'((s > 0) && (s % 15 == 0)));
      chk("so", 128'(so), 128'((s / 15) % 256));
      for (int sel = 0; sel < 3; sel++) begin
         tq = (sel == 0) ? temp_A : (sel == 1) ? temp_B : temp_C;
         for (int i = 0; i < 15; i++) begin
            m = s - 15 + i;
            slot_exp = (m >= 0) ? ref_fir(row_at(m), sel) : 64'd0;
            if (tq[64*i +: 64] !== slot_exp) begin
               fails++;
               $display("FAIL temp_%0d slot %0d at edge %0d: got %h expected %h",
                        sel, i, n, tq[64*i +: 64], slot_exp);
            end
            tests++;
         end
      end
   endtask

   initial begin
      vec_t vecs [6];
      logic [119:0] r;
      int edges;

      vecs[0] = '{row: {15{8'h80}}, ea: 64'h8080808080808080, eb: 64'h8080808080808080, ec: 64'h8080808080808080};
      vecs[1] = '{row: 120'hFF << 56, ea: 64'h001000E744000400, eb: 64'h0010009F9F001000, ec: 64'h00040044E7001000};
      vecs[2] = '{row: '0, ea: 64'h0, eb: 64'h0, ec: 64'h0};
      vecs[3] = '{row: {15{8'hFF}}, ea: 64'hFFFFFFFFFFFFFFFF, eb: 64'hFFFFFFFFFFFFFFFF, ec: 64'hFFFFFFFFFFFFFFFF};
      vecs[4] = '{row: 120'h40 << 24, ea: 64'h000000000004003A, eb: 64'h0000000000040028, ec: 64'h0000000000010011};
      vecs[5] = '{row: 120'hFF, ea: 64'h0, eb: 64'h0, ec: 64'h0};

      for (int i = 0; i < 64; i++) begin
         for (int b = 0; b < 4; b++)
            r[32*b +: 32] = $urandom;
         rows[i] = r;
      end
      use_fixed = 1'b0;
      fixed_row = '0;

      // Two cycles of reset: everything cleared.
      rst = 1'b1;
      tick();
      tick();
      check_state(0);

      // Filter vectors: each row loaded for one edge, then outputs compared.
      use_fixed = 1'b1;
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         fixed_row = vecs[i].row;
         tick();
         chk($sformatf("vec%0d_cur", i), 128'(currentPixels), 128'(vecs[i].row));
         chk($sformatf("vec%0d_a", i), 128'(fir_out_a), 128'(vecs[i].ea));
         chk($sformatf("vec%0d_b", i), 128'(fir_out_b), 128'(vecs[i].eb));
         chk($sformatf("vec%0d_c", i), 128'(fir_out_c), 128'(vecs[i].ec));
      end

      // Random rows streamed from reset release through two block boundaries.
      use_fixed = 1'b0;
      rst = 1'b1;
      tick();
      check_state(0);
      rst = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         tick();
         check_state(n);
      end

      // Reset mid-block (cnt=7) discards the partial block.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int n = 1; n <= 8; n++)
         tick();
      chk("cnt_before_midreset", 128'(cnt), 128'd7);
      rst = 1'b1;
      tick();
      check_state(0);
      rst = 1'b0;
      edges = 0;
      while (edges < 40) begin
         tick();
         edges++;
         check_state(edges);
         if (load_out === 1'b1) break;
      end
      chk("first_load_edge_after_midreset", 128'(edges), 128'd16);
      chk("so_after_first_block", 128'(so), 128'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
